rom_burst_reader: RTL and testbench

- Parametrised successor to the single-port synchronous ROM.
- Holds a MEM_SIZE x DATA_BITS read-only array and accepts burst requests (start address, length).
- Streams the words out on a valid/ready interface with full backpressure, wrap-around addressing, abort and error reporting.
- Sits between the accelerator controller and the PE array; it feeds weights and bias constants without the controller sequencing CS/OE per word.

---
 rtl/rom_burst_reader_pkg.sv | 18 +
 rtl/rom_burst_reader_bank.sv | 27 ++
 rtl/rom_burst_reader.sv | 173 +++++++++++++++++
 tb/tb_rom_burst_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rom_burst_reader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rom_burst_reader_pkg : shared widths and FSM encoding             |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package rom_burst_reader_pkg;

  localparam int ROM_DATA_BITS = 32;
  localparam int FIFO_DEPTH    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rom_burst_reader_bank.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rom_bank : synchronous-read array, one-cycle latency              |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module rom_bank #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 10,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 CK,
  input  logic                 CS,
  input  logic [ADDR_BITS-1:0] A,
  output logic [DATA_BITS-1:0] DO
);

  // Contents are loaded from outside through the hierarchy; no write port.
  logic [DATA_BITS-1:0] Memory [MEM_SIZE];

  always_ff @(posedge CK) begin
    if (CS) begin
      DO <= Memory[A];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rom_burst_reader : burst ROM reader with valid/ready output       |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int DATA_BITS = ROM_DATA_BITS,
  parameter int ADDR_BITS = 10,
  parameter int MEM_SIZE  = 1024,
  parameter int LEN_BITS  = 8
) (
  input  logic                 CK,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 abort,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_BITS = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int EW       = DATA_BITS + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_SIZE - 1);
  localparam logic [ADDR_BITS:0]   SIZE_EXT  = (ADDR_BITS + 1)'(MEM_SIZE);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  rem_q, rem_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic [1:0]           count_q, count_d;
  logic [EW-1:0]        fifo_q [FIFO_DEPTH];
  logic [EW-1:0]        fifo_d [FIFO_DEPTH];
  logic                 err_q, err_d;

  logic [DATA_BITS-1:0] rd_data;
  logic [EW-1:0]        new_entry;
  logic [1:0]           used;
  logic                 pop, push, issue, flush, addr_bad;

  assign pop       = (count_q != 2'd0) && dout_ready;
  assign push      = inflight_q;
  assign flush     = abort && (state_q != IDLE);
  assign used      = count_q + {1'b0, inflight_q};
  // A same-cycle pop frees a slot, which keeps the stream bubble-free.
  assign issue     = (state_q == BURST) && !abort && ((used < 2'd2) || pop);
  assign addr_bad  = {1'b0, req_addr} >= SIZE_EXT;
  assign new_entry = {inflight_last_q, rd_data};

  rom_bank #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(IDX_BITS),
    .MEM_SIZE (MEM_SIZE)
  ) u_bank (
    .CK(CK),
    .CS(issue),
    .A (addr_q[IDX_BITS-1:0]),
    .DO(rd_data)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    err_d           = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == '0);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = BURST;
            addr_d  = req_addr;
            rem_d   = req_len;
          end
        end
      end
      BURST: begin
        if (issue) begin
          addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == '0) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_q[0][DATA_BITS]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            fifo_d[0] = new_entry;
          end else begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = new_entry;
          end
        end
        2'b01: begin
          fifo_d[0] = fifo_q[1];
          count_d   = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            fifo_d[0] = new_entry;
          end else begin
            fifo_d[1] = new_entry;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= 2'd0;
      err_q           <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      err_q           <= err_d;
      fifo_q          <= fifo_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign dout_valid = (count_q != 2'd0);
  assign dout       = fifo_q[0][DATA_BITS-1:0];
  assign dout_last  = fifo_q[0][DATA_BITS];

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_rom_burst_reader : randomized bench with queue reference model |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_rom_burst_reader;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int MS = 1024;
  localparam int LW = 8;

  logic          CK = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          abort = 1'b0;
  logic          dout_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          req_ready, dout_valid, dout_last, busy, err;
  logic [DW-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] mem [MS];

  always #5 CK = ~CK;

  rom_burst_reader #(
    .DATA_BITS(DW), .ADDR_BITS(AW), .MEM_SIZE(MS), .LEN_BITS(LW)
  ) dut (
    .CK(CK), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .abort(abort),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_last(dout_last), .busy(busy), .err(err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input bit ramp);
    for (int i = 0; i < MS; i++) begin
      mem[i] = ramp ? DW'(i) : DW'($urandom);
      dut.u_bank.Memory[i] = mem[i];
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // mode: 0 ready always, 1 ready 1,0,0 pattern, 2 random ready.
  // stop_after >= 0 interrupts after that many handshakes (abort, or reset if stop_rst).
  task automatic do_burst(input int addr, input int len, input int mode,
                          input int stop_after, input bit stop_rst);
    logic [DW:0] exp_q [$];
    logic [DW:0] exp_w, prev;
    int cyc, hs, first_cyc, budget, seen;
    bit done, stall_prev, aborted, was_reset;
    for (int k = 0; k <= len; k++) begin
      exp_q.push_back({k == len, mem[(addr + k) % MS]});
    end
    @(posedge CK); #1;
    req_valid = 1'b1; req_addr = AW'(addr); req_len = LW'(len); abort = 1'b0;
    @(posedge CK); #1;
    req_valid = 1'b0;
    cyc = 0; hs = 0; first_cyc = -1; budget = 4 * (len + 1) + 20;
    done = 0; stall_prev = 0; aborted = 0; was_reset = 0; prev = '0;
    while (!done && cyc < budget) begin
      dout_ready = pick_ready(mode, cyc);
      abort = (stop_after >= 0) && !stop_rst && (hs == stop_after);
      if (stop_rst && hs == stop_after) begin
        #1 rst = 1'b1;
        #1 check_eq("async_reset_outs",
                    {dout_valid, dout_last, err, busy, req_ready, dout}, {5'b00001, DW'(0)});
        @(negedge CK); rst = 1'b0;
        was_reset = 1; done = 1;
      end else begin
        @(negedge CK);
        if (dout_valid) begin
          if (first_cyc < 0) begin
            first_cyc = cyc;
            check_eq("first_latency", cyc, 2);
          end
          if (stall_prev) check_eq("stall_hold", {dout_last, dout}, prev);
          if (dout_ready && !abort) begin
            if (exp_q.size() == 0) begin
              check_eq("extra_word", {dout_last, dout}, '1);
            end else begin
              exp_w = exp_q.pop_front();
              check_eq("word", {dout_last, dout}, exp_w);
              if (mode == 0) check_eq("no_bubble", cyc, hs + 2);
              if (exp_w[DW]) done = 1;
            end
            hs++;
          end
        end
        stall_prev = dout_valid && !dout_ready && !abort;
        prev = {dout_last, dout};
        if (abort) begin
          aborted = 1; done = 1;
        end
        @(posedge CK); #1;
        cyc++;
      end
    end
    abort = 1'b0;
    if (!done) check_eq("timeout_handshakes", hs, len + 1);
    if (was_reset) return;
    @(negedge CK);
    check_eq("end_idle", {busy, req_ready, dout_valid}, 3'b010);
    if (aborted) begin
      seen = 0;
      dout_ready = 1'b1;
      repeat (5) begin
        @(negedge CK);
        if (dout_valid) seen++;
      end
      check_eq("no_words_after_abort", seen, 0);
    end
  endtask

  task automatic err_test(input int addr);
    int seen;
    @(posedge CK); #1;
    req_valid = 1'b1; req_addr = AW'(addr); req_len = '0;
    @(posedge CK); #1;
    req_valid = 1'b0;
    @(negedge CK);
    check_eq("err_pulse", {err, dout_valid, req_ready, busy}, 4'b1010);
    @(negedge CK);
    check_eq("err_clear", {err, req_ready}, 2'b01);
    seen = 0;
    repeat (4) begin
      @(negedge CK);
      if (dout_valid || busy) seen++;
    end
    check_eq("err_no_data", seen, 0);
  endtask

  initial begin
    int a, l, m, s;
    preload(1'b1);
    repeat (3) @(posedge CK);
    @(negedge CK);
    check_eq("reset_state",
             {dout_valid, dout_last, err, busy, req_ready, dout}, {5'b00001, DW'(0)});
    rst = 1'b0;

    do_burst(5, 3, 0, -1, 1'b0);
    do_burst(1022, 4, 0, -1, 1'b0);
    do_burst(0, 7, 1, -1, 1'b0);
    do_burst(0, 15, 0, 3, 1'b0);
    do_burst(100, 0, 0, -1, 1'b0);
    err_test(1024);
    err_test(2047);
    do_burst(10, 20, 0, 5, 1'b1);
    do_burst(10, 0, 0, -1, 1'b0);

    preload(1'b0);
    for (int t = 0; t < 16; t++) begin
      a = $urandom_range(0, MS - 1);
      if (t % 4 == 0) a = MS - 1 - $urandom_range(0, 5);
      l = $urandom_range(0, 40);
      m = $urandom_range(0, 2);
      s = (t % 5 == 4 && l > 0) ? $urandom_range(0, l) : -1;
      do_burst(a, l, m, s, 1'b0);
    end
    do_burst(900, 255, 2, -1, 1'b0);
    do_burst(1000, 255, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
